// File: rtl/seq_div_top.sv
// Iterative radix-2 restoring divider: 2*DW-bit dividend / DW-bit divisor -> DW-bit quotient and remainder.
// One quotient bit per clock behind a start/busy/done handshake; exceptions complete in a single cycle.
module seq_div_top #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero,
    output logic            ovf
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   rem;
    logic [DW-1:0]   shreg;
    logic [DW-1:0]   dvsr;

    logic            accept;
    logic            is_zero;
    logic            is_ovf;
    logic            last;
    logic [DW:0]     t;
    logic            ge;
    logic [DW-1:0]   rem_step;

    assign accept  = start && (state != CALC);
    assign is_zero = (divisor == '0);
    assign is_ovf  = (dividend[2*DW-1:DW] >= divisor);
    assign last    = (state == CALC) && (cnt == CW'(DW - 1));

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    always_comb begin
        t        = {rem, shreg[DW-1]};
        ge       = (t >= {1'b0, dvsr});
        rem_step = ge ? DW'(t - {1'b0, dvsr}) : t[DW-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every branch falls back to the default below, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start)               state_nxt = (is_zero || is_ovf) ? DONE : CALC;
                else if (state == DONE)  state_nxt = IDLE;
            end
            CALC:    if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // Quotient bits enter shreg's LSB as dividend bits leave its MSB, so after DW steps it holds the quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            shreg       <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else if (accept) begin
            dvsr        <= divisor;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
            if (is_zero) begin
                div_by_zero <= 1'b1;
                quotient    <= '1;
                remainder   <= dividend[DW-1:0];
            end else if (is_ovf) begin
                ovf         <= 1'b1;
                quotient    <= '1;
                remainder   <= '0;
            end else begin
                rem         <= dividend[2*DW-1:DW];
                shreg       <= dividend[DW-1:0];
                cnt         <= '0;
            end
        end else if (state == CALC) begin
            rem   <= rem_step;
            shreg <= {shreg[DW-2:0], ge};
            cnt   <= cnt + 1'b1;
            if (last) begin
                quotient  <= {shreg[DW-2:0], ge};
                remainder <= rem_step;
            end
        end
    end

endmodule

// File: tb/tb_seq_div_top.sv
// Self-checking bench for seq_div_top: directed vector table, multi-cycle corner sequences,
// and randomized operands checked against an arithmetic reference model.
module tb_seq_div_top;

    localparam int DW = 16;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [2*DW-1:0] dividend;
    logic [DW-1:0]   divisor;
    logic            busy;
    logic            done;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            div_by_zero;
    logic            ovf;

    int checks = 0;
    int errors = 0;

    seq_div_top #(.DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dd;
        logic [15:0] dv;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ov;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Division defined by plain arithmetic: out-of-range quotients saturate with ovf.
    function automatic void model(input logic [31:0] dd, input logic [15:0] dv,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dbz, output logic ov);
        longint unsigned a, b, qq;
        a = 64'(dd);
        b = 64'(dv);
        dbz = 1'b0;
        ov  = 1'b0;
        if (dv == 0) begin
            dbz = 1'b1; q = 16'hFFFF; r = dd[15:0];
        end else begin
            qq = a / b;
            if (qq > 64'd65535) begin
                ov = 1'b1; q = 16'hFFFF; r = 16'h0;
            end else begin
                q = 16'(qq); r = 16'(a % b);
            end
        end
    endfunction

    // Called at the first falling edge after the accept edge; counts edges until done and busy samples.
    task automatic wait_done(output int edge_n, output int bcnt);
        edge_n = 0;
        bcnt   = 0;
        while (!done && edge_n < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            edge_n++;
        end
    endtask

    task automatic run_op(input logic [31:0] dd, input logic [15:0] dv,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edbz, input logic eov, input string tag);
        int edge_n, bcnt;
        int exp_lat;
        exp_lat = (edbz || eov) ? 0 : DW;
        @(negedge clk);
        dividend = dd; divisor = dv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(edge_n, bcnt);
        check({tag, " latency"}, 64'(edge_n), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(exp_lat));
        check({tag, " quotient"}, 64'(quotient), 64'(eq));
        check({tag, " remainder"}, 64'(remainder), 64'(er));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
        check({tag, " ovf"}, 64'(ovf), 64'(eov));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        check({tag, " result_hold"}, 64'({quotient, remainder}), 64'({eq, er}));
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] eq, er;
        logic        edbz, eov;
        int          edge_n, bcnt, dcnt;
        logic [31:0] dd;
        logic [15:0] dv;

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

        vecs.push_back('{32'd1000,       16'd7,      16'd142,    16'd6,      1'b0, 1'b0});
        vecs.push_back('{32'hFFFE0001,   16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0});
        vecs.push_back('{32'h00010000,   16'd2,      16'h8000,   16'h0000,   1'b0, 1'b0});
        vecs.push_back('{32'h12345678,   16'd0,      16'hFFFF,   16'h5678,   1'b1, 1'b0});
        vecs.push_back('{32'h00050000,   16'd5,      16'hFFFF,   16'h0000,   1'b0, 1'b1});
        vecs.push_back('{32'hFFFFFFFF,   16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b1});
        vecs.push_back('{32'h00000000,   16'd1,      16'h0000,   16'h0000,   1'b0, 1'b0});
        vecs.push_back('{32'h0000FFFF,   16'd1,      16'hFFFF,   16'h0000,   1'b0, 1'b0});
        vecs.push_back('{32'h7FFFFFFF,   16'h8000,   16'hFFFF,   16'h7FFF,   1'b0, 1'b0});
        vecs.push_back('{32'h00000000,   16'd0,      16'hFFFF,   16'h0000,   1'b1, 1'b0});
        vecs.push_back('{32'd50000,      16'd300,    16'd166,    16'd200,    1'b0, 1'b0});

        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset outputs", 64'({quotient, remainder, div_by_zero, ovf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ov,
                   $sformatf("vec%0d", i));

        // Start pulsed mid-calculation with other operands must be ignored.
        @(negedge clk);
        dividend = 32'd1000; divisor = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        dividend = 32'h00000100; divisor = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(edge_n, bcnt);
        check("ignore latency", 64'(edge_n + 6), 64'd16);
        check("ignore quotient", 64'(quotient), 64'd142);
        check("ignore remainder", 64'(remainder), 64'd6);
        check("ignore flags", 64'({div_by_zero, ovf}), 64'd0);

        // Start held through the DONE cycle: second op accepted back-to-back.
        dividend = 32'h00012345; divisor = 16'h0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b done_drop", 64'(done), 64'd0);
        check("b2b busy", 64'(busy), 64'd1);
        check("b2b old_held", 64'(quotient), 64'd142);
        wait_done(edge_n, bcnt);
        check("b2b latency", 64'(edge_n), 64'd16);
        check("b2b quotient", 64'(quotient), 64'h0123);
        check("b2b remainder", 64'(remainder), 64'h0045);

        // Reset during CALC aborts without a done.
        @(negedge clk);
        dividend = 32'd1000; divisor = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort outputs", 64'({done, quotient, remainder, div_by_zero, ovf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort no_done", 64'(dcnt), 64'd0);
        model(32'd50000, 16'd300, eq, er, edbz, eov);
        run_op(32'd50000, 16'd300, eq, er, edbz, eov, "post_abort");

        for (int n = 0; n < 2500; n++) begin
            dv = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dv = 16'h0;
            dd = $urandom;
            if (dv != 0 && $urandom_range(0, 3) != 0)
                dd[31:16] = 16'($urandom_range(0, int'(dv) - 1));
            model(dd, dv, eq, er, edbz, eov);
            run_op(dd, dv, eq, er, edbz, eov, $sformatf("rand%0d", n));
            if (!edbz && !eov) begin
                check($sformatf("rand%0d invariant", n),
                      64'(quotient) * 64'(dv) + 64'(remainder), 64'(dd));
                check($sformatf("rand%0d rem_lt_div", n), 64'(remainder < dv), 64'd1);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
